ddr_rd_arbiter: RTL and testbench

Read-channel arbiter and scheduler for the shared DDR controller AXI read port. It accepts burst read requests from four read masters (frame readers, line-buffer fetch) and grants them round-robin, one burst outstanding at a time. It forwards the winning request to the controller's `axi_ar*` port and steers returned `axi_r*` beats back to the granted master. It sits beside the write-side interconnect, between the video read engines and the DDR IP.

---
 rtl/ddr_rd_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: round-robin read arbiter for the shared DDR AXI read port.
// Four read masters request bursts; one burst is outstanding at a time.
// Ports:
//   ACLK, ARESET          - clock, synchronous active-high reset
//   mN_AR*                - request channel of master N (N = 0..3)
//   mN_R*                 - read-data return to master N
//   axi_ar*               - forwarded request to the DDR controller
//   axi_r*                - read data from the DDR controller
//   grant, busy           - current/last granted master, burst in flight
//   err_len, err_timeout  - one-cycle error pulses
module ddr_rd_arbiter #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [3:0]            m0_ARID,
  input  logic [ADDR_WIDTH-1:0] m0_ARADDR,
  input  logic [7:0]            m0_ARLEN,
  input  logic                  m0_ARVALID,
  output logic                  m0_ARREADY,
  output logic [DATA_WIDTH-1:0] m0_RDATA,
  output logic                  m0_RVALID,
  output logic                  m0_RLAST,
  input  logic [3:0]            m1_ARID,
  input  logic [ADDR_WIDTH-1:0] m1_ARADDR,
  input  logic [7:0]            m1_ARLEN,
  input  logic                  m1_ARVALID,
  output logic                  m1_ARREADY,
  output logic [DATA_WIDTH-1:0] m1_RDATA,
  output logic                  m1_RVALID,
  output logic                  m1_RLAST,
  input  logic [3:0]            m2_ARID,
  input  logic [ADDR_WIDTH-1:0] m2_ARADDR,
  input  logic [7:0]            m2_ARLEN,
  input  logic                  m2_ARVALID,
  output logic                  m2_ARREADY,
  output logic [DATA_WIDTH-1:0] m2_RDATA,
  output logic                  m2_RVALID,
  output logic                  m2_RLAST,
  input  logic [3:0]            m3_ARID,
  input  logic [ADDR_WIDTH-1:0] m3_ARADDR,
  input  logic [7:0]            m3_ARLEN,
  input  logic                  m3_ARVALID,
  output logic                  m3_ARREADY,
  output logic [DATA_WIDTH-1:0] m3_RDATA,
  output logic                  m3_RVALID,
  output logic                  m3_RLAST,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [3:0]            axi_aruser_id,
  output logic [3:0]            axi_arlen,
  output logic                  axi_aruser_ap,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [3:0]            axi_rid,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  err_len,
  output logic                  err_timeout
);

  localparam int unsigned WDOG_W = 10;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t                state_q;
  logic [1:0]            grant_q, rr_ptr_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [3:0]            arid_q, arlen_q, exp_id_q, exp_len_q, beat_cnt_q;
  logic                  arvalid_q, err_len_q, err_timeout_q;
  logic [WDOG_W-1:0]     wdog_q;

  logic [3:0]            req;
  logic [1:0]            pick_d;
  logic [ADDR_WIDTH-1:0] sel_addr_d;
  logic [3:0]            sel_id_d, sel_len_d;
  logic                  beat, ar_hs;

  // ARLEN[7:4] is ignored: bursts are limited to 16 beats
  logic unused_arlen_hi;
  assign unused_arlen_hi = ^{m0_ARLEN[7:4], m1_ARLEN[7:4], m2_ARLEN[7:4], m3_ARLEN[7:4]};

  assign req = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};

  // First requester at or after rr_ptr, searching cyclically upward
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found  = 1'b0;
    idx    = rr_ptr_q;
    pick_d = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        pick_d = idx;
      end
    end
  end

  // Request field mux for the winning master
  always_comb begin
    sel_addr_d = m0_ARADDR;
    sel_id_d   = m0_ARID;
    sel_len_d  = m0_ARLEN[3:0];
    case (pick_d)
      2'd1:    begin sel_addr_d = m1_ARADDR; sel_id_d = m1_ARID; sel_len_d = m1_ARLEN[3:0]; end
      2'd2:    begin sel_addr_d = m2_ARADDR; sel_id_d = m2_ARID; sel_len_d = m2_ARLEN[3:0]; end
      2'd3:    begin sel_addr_d = m3_ARADDR; sel_id_d = m3_ARID; sel_len_d = m3_ARLEN[3:0]; end
      default: begin sel_addr_d = m0_ARADDR; sel_id_d = m0_ARID; sel_len_d = m0_ARLEN[3:0]; end
    endcase
  end

  // Beats whose rid differs from the issued ID belong to someone else
  assign beat  = ~ARESET & (state_q == ST_DATA) & axi_rvalid & (axi_rid == exp_id_q);
  assign ar_hs = ~ARESET & (state_q == ST_ADDR) & arvalid_q & axi_arready;

  // Arbiter state machine and registered outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      grant_q       <= 2'd0;
      rr_ptr_q      <= 2'd0;
      araddr_q      <= '0;
      arid_q        <= 4'd0;
      arlen_q       <= 4'd0;
      arvalid_q     <= 1'b0;
      exp_id_q      <= 4'd0;
      exp_len_q     <= 4'd0;
      beat_cnt_q    <= 4'd0;
      wdog_q        <= '0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant_q   <= pick_d;
            araddr_q  <= sel_addr_d;
            arid_q    <= sel_id_d;
            arlen_q   <= sel_len_d;
            arvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ar_hs) begin
            arvalid_q  <= 1'b0;
            exp_id_q   <= arid_q;
            exp_len_q  <= arlen_q;
            beat_cnt_q <= 4'd0;
            wdog_q     <= '0;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            wdog_q <= '0;
            if (beat_cnt_q != 4'd15) beat_cnt_q <= beat_cnt_q + 4'd1;
            if (axi_rlast) begin
              // beat_cnt_q is the 0-based index of this last beat
              if (beat_cnt_q != exp_len_q) err_len_q <= 1'b1;
              rr_ptr_q <= grant_q + 2'd1;
              state_q  <= ST_IDLE;
            end
          end else if (wdog_q == WDOG_LAST) begin
            // TIMEOUT consecutive cycles without a beat: abandon the burst
            err_timeout_q <= 1'b1;
            rr_ptr_q      <= grant_q + 2'd1;
            state_q       <= ST_IDLE;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi_araddr    = araddr_q;
  assign axi_aruser_id = arid_q;
  assign axi_arlen     = arlen_q;
  assign axi_aruser_ap = 1'b1;
  assign axi_arvalid   = arvalid_q;
  assign grant         = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign err_len       = err_len_q;
  assign err_timeout   = err_timeout_q;

  assign m0_ARREADY = ar_hs & (grant_q == 2'd0);
  assign m1_ARREADY = ar_hs & (grant_q == 2'd1);
  assign m2_ARREADY = ar_hs & (grant_q == 2'd2);
  assign m3_ARREADY = ar_hs & (grant_q == 2'd3);

  assign m0_RVALID = beat & (grant_q == 2'd0);
  assign m1_RVALID = beat & (grant_q == 2'd1);
  assign m2_RVALID = beat & (grant_q == 2'd2);
  assign m3_RVALID = beat & (grant_q == 2'd3);

  assign m0_RLAST = m0_RVALID & axi_rlast;
  assign m1_RLAST = m1_RVALID & axi_rlast;
  assign m2_RLAST = m2_RVALID & axi_rlast;
  assign m3_RLAST = m3_RVALID & axi_rlast;

  assign m0_RDATA = axi_rdata;
  assign m1_RDATA = axi_rdata;
  assign m2_RDATA = axi_rdata;
  assign m3_RDATA = axi_rdata;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: directed bench for ddr_rd_arbiter (TIMEOUT = 16).
// A cycle table covers a single burst and a foreign-ID interleave; hand
// sequences cover round robin, length error, timeout and reset mid-burst.
module tb_ddr_rd_arbiter;

  localparam int unsigned DW = 256;
  localparam int unsigned AW = 28;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [3:0]    arv, ardy_v, rv_v, rl_v;
  logic          ardy, rv, rl;
  logic [3:0]    rid;
  logic [DW-1:0] rdata;
  logic [3:0]    m_arid [4];
  logic [AW-1:0] m_araddr [4];
  logic [7:0]    m_arlen [4];
  logic [DW-1:0] m_rdata [4];
  logic [AW-1:0] axi_araddr;
  logic [3:0]    axi_aruser_id, axi_arlen;
  logic          axi_aruser_ap, axi_arvalid, busy, err_len, err_timeout;
  logic [1:0]    grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  ddr_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_ARID(m_arid[0]), .m0_ARADDR(m_araddr[0]), .m0_ARLEN(m_arlen[0]), .m0_ARVALID(arv[0]),
    .m0_ARREADY(ardy_v[0]), .m0_RDATA(m_rdata[0]), .m0_RVALID(rv_v[0]), .m0_RLAST(rl_v[0]),
    .m1_ARID(m_arid[1]), .m1_ARADDR(m_araddr[1]), .m1_ARLEN(m_arlen[1]), .m1_ARVALID(arv[1]),
    .m1_ARREADY(ardy_v[1]), .m1_RDATA(m_rdata[1]), .m1_RVALID(rv_v[1]), .m1_RLAST(rl_v[1]),
    .m2_ARID(m_arid[2]), .m2_ARADDR(m_araddr[2]), .m2_ARLEN(m_arlen[2]), .m2_ARVALID(arv[2]),
    .m2_ARREADY(ardy_v[2]), .m2_RDATA(m_rdata[2]), .m2_RVALID(rv_v[2]), .m2_RLAST(rl_v[2]),
    .m3_ARID(m_arid[3]), .m3_ARADDR(m_araddr[3]), .m3_ARLEN(m_arlen[3]), .m3_ARVALID(arv[3]),
    .m3_ARREADY(ardy_v[3]), .m3_RDATA(m_rdata[3]), .m3_RVALID(rv_v[3]), .m3_RLAST(rl_v[3]),
    .axi_araddr(axi_araddr), .axi_aruser_id(axi_aruser_id), .axi_arlen(axi_arlen),
    .axi_aruser_ap(axi_aruser_ap), .axi_arvalid(axi_arvalid), .axi_arready(ardy),
    .axi_rdata(rdata), .axi_rid(rid), .axi_rlast(rl), .axi_rvalid(rv),
    .grant(grant), .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [3:0]  arv;
    logic        ardy;
    logic        rv;
    logic [3:0]  rid;
    logic        rl;
    logic [53:0] exp;
  } vec_t;

  vec_t vecs [19];

  // Drive point: just after the rising edge. Sample point: falling edge.
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic smp();
    @(negedge ACLK);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observed output snapshot, same layout as the table's expected field
  function automatic logic [53:0] snap();
    return {axi_arvalid, ardy_v, rv_v, rl_v, busy, grant, axi_araddr, axi_aruser_id,
            axi_arlen, err_len, err_timeout};
  endfunction

  // mf selects whose request fields should sit in axi_ar* (4 = reset zeros)
  function automatic vec_t v(input logic [3:0] a, input logic ar, input logic r,
                             input logic [3:0] id, input logic l, input logic e_arv,
                             input logic [3:0] e_ardy, input logic [3:0] e_rv,
                             input logic [3:0] e_rl, input logic e_busy,
                             input logic [1:0] e_grant, input int mf);
    vec_t t;
    logic [AW-1:0] ad;
    logic [3:0]    eid, eln;
    ad = '0; eid = 4'd0; eln = 4'd0;
    if (mf < 4) begin
      ad = m_araddr[mf]; eid = m_arid[mf]; eln = m_arlen[mf][3:0];
    end
    t.arv = a; t.ardy = ar; t.rv = r; t.rid = id; t.rl = l;
    t.exp = {e_arv, e_ardy, e_rv, e_rl, e_busy, e_grant, ad, eid, eln, 2'b00};
    return t;
  endfunction

  task automatic do_reset();
    ARESET = 1'b1; arv = 4'b0; ardy = 1'b0; rv = 1'b0; rl = 1'b0; rid = 4'd0;
    cyc();
    cyc();
    ARESET = 1'b0;
  endtask

  // One complete burst for master m with nb beats, rlast on the last one
  task automatic burst(input int m, input int nb, output logic saw_err);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << m;
    arv[m] = 1'b1; ardy = 1'b1;
    n = 0;
    smp();
    while (!axi_arvalid && n < 8) begin
      cyc(); smp(); n++;
    end
    chk("burst_arvalid", 64'(axi_arvalid), 64'(1));
    chk("burst_grant", 64'(grant), 64'(m));
    chk("burst_arready", 64'(ardy_v), 64'(oh));
    cyc();
    arv[m] = 1'b0; ardy = 1'b0;
    for (int b = 0; b < nb; b++) begin
      rv = 1'b1; rid = m_arid[m]; rl = (b == nb - 1);
      smp();
      chk("burst_beat", 64'({rv_v, rl_v}), 64'({oh, (b == nb - 1) ? oh : 4'b0}));
      cyc();
    end
    rv = 1'b0; rl = 1'b0;
    smp();
    saw_err = err_len;
    chk("burst_idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    logic e;
    int j, n, busy_lo;
    logic [1:0] rr_exp [5];

    m_arid[0] = 4'd1; m_araddr[0] = 28'h0000100; m_arlen[0] = 8'd0;
    m_arid[1] = 4'd3; m_araddr[1] = 28'h0002000; m_arlen[1] = 8'd3;
    m_arid[2] = 4'd5; m_araddr[2] = 28'h0001000; m_arlen[2] = 8'd3;
    m_arid[3] = 4'd9; m_araddr[3] = 28'h0003000; m_arlen[3] = 8'd3;
    rdata = '0;

    // m2 single burst (accept 2 cycles after arvalid), then m1 with rid 7 interleaved
    vecs[0]  = v(4'b0100, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 4);
    vecs[1]  = v(4'b0100, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 2);
    vecs[2]  = v(4'b0100, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 2);
    vecs[3]  = v(4'b0100, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 2);
    vecs[4]  = v(4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 2);
    vecs[5]  = v(4'b0000, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2, 2);
    vecs[6]  = v(4'b0000, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2, 2);
    vecs[7]  = v(4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 2);
    vecs[8]  = v(4'b0000, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2, 2);
    vecs[9]  = v(4'b0000, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0100, 1'b1, 2'd2, 2);
    vecs[10] = v(4'b0010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 2);
    vecs[11] = v(4'b0010, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd1, 1);
    vecs[12] = v(4'b0000, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1);
    vecs[13] = v(4'b0000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1, 1);
    vecs[14] = v(4'b0000, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1);
    vecs[15] = v(4'b0000, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1, 1);
    vecs[16] = v(4'b0000, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1);
    vecs[17] = v(4'b0000, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b1, 2'd1, 1);
    vecs[18] = v(4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1);

    // Reset state
    ARESET = 1'b1; arv = 4'b0; ardy = 1'b0; rv = 1'b0; rl = 1'b0; rid = 4'd0;
    cyc(); cyc();
    smp();
    chk("reset_state", 64'(snap()), 64'(0));
    chk("reset_aruser_ap", 64'(axi_aruser_ap), 64'(1));
    cyc();
    ARESET = 1'b0;

    for (int i = 0; i < 19; i++) begin
      arv = vecs[i].arv; ardy = vecs[i].ardy; rv = vecs[i].rv;
      rid = vecs[i].rid; rl = vecs[i].rl;
      smp();
      chk($sformatf("vec%0d", i), 64'(snap()), 64'(vecs[i].exp));
      cyc();
    end
    arv = 4'b0; ardy = 1'b0; rv = 1'b0; rl = 1'b0;

    // Round robin: all four request len 0 from rr_ptr 0
    do_reset();
    for (int m = 0; m < 4; m++) m_arlen[m] = 8'd0;
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;
    arv = 4'b1111; ardy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0; busy_lo = 0;
      smp();
      while (!axi_arvalid && n < 10) begin
        if (!busy) busy_lo++;
        cyc(); smp(); n++;
      end
      chk($sformatf("rr%0d_grant", k), 64'(grant), 64'(rr_exp[k]));
      chk($sformatf("rr%0d_arready", k), 64'(ardy_v), 64'(4'b0001 << rr_exp[k]));
      if (k > 0) chk($sformatf("rr%0d_bubble", k), 64'(busy_lo), 64'(1));
      cyc();
      rv = 1'b1; rl = 1'b1; rid = m_arid[rr_exp[k]];
      if (k == 4) arv = 4'b0;
      smp();
      chk($sformatf("rr%0d_rvalid", k), 64'(rv_v), 64'(4'b0001 << rr_exp[k]));
      cyc();
      rv = 1'b0; rl = 1'b0;
    end
    ardy = 1'b0;
    smp(); cyc();

    // Length error: arlen 7 but rlast on beat 5; rr_ptr is 1 here
    m_arlen[1] = 8'd7;
    burst(1, 5, e);
    chk("len_err_pulse", 64'(e), 64'(1));
    cyc(); smp();
    chk("len_err_oneshot", 64'(err_len), 64'(0));
    cyc();
    burst(0, 1, e);
    chk("len_err_next_ok", 64'(e), 64'(0));
    cyc();

    // Timeout: m2 gets 2 of 4 beats; m1 and m3 wait; rr_ptr should move to 3
    m_arlen[1] = 8'd0; m_arlen[3] = 8'd0;
    arv = 4'b0100; ardy = 1'b1;
    n = 0;
    smp();
    while (!axi_arvalid && n < 8) begin
      cyc(); smp(); n++;
    end
    chk("to_grant", 64'(grant), 64'(2));
    cyc();
    arv = 4'b1010; ardy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rv = 1'b1; rid = 4'd5; rl = 1'b0;
      smp();
      chk("to_beat", 64'(rv_v), 64'(4'b0100));
      cyc();
    end
    rv = 1'b0;
    // 16 beat-less cycles after the 2nd beat; the pulse follows on the next one
    j = 1;
    smp();
    while (!err_timeout && j < 40) begin
      cyc(); smp(); j++;
    end
    chk("to_cycle", 64'(j), 64'(17));
    chk("to_idle", 64'(busy), 64'(0));
    cyc();
    rv = 1'b1; rid = 4'd5; rl = 1'b1; ardy = 1'b1;
    smp();
    chk("to_next", 64'({axi_arvalid, grant, rv_v, err_timeout}), 64'({1'b1, 2'd3, 4'b0000, 1'b0}));
    cyc();
    arv = 4'b0010; ardy = 1'b0; rv = 1'b1; rid = 4'd5; rl = 1'b0;
    smp();
    chk("to_stray", 64'(rv_v), 64'(0));
    cyc();
    rid = 4'd9; rl = 1'b1;
    smp();
    chk("to_m3_beat", 64'({rv_v, rl_v}), 64'({4'b1000, 4'b1000}));
    cyc();
    rv = 1'b0; rl = 1'b0;
    burst(1, 1, e);
    chk("to_m1_ok", 64'(e), 64'(0));
    cyc();

    // Reset mid-DATA after the first beat of an m2 burst
    m_arlen[2] = 8'd3;
    arv = 4'b0100; ardy = 1'b1;
    n = 0;
    smp();
    while (!axi_arvalid && n < 8) begin
      cyc(); smp(); n++;
    end
    chk("rst_grant", 64'(grant), 64'(2));
    cyc();
    arv = 4'b0000; ardy = 1'b0; rv = 1'b1; rid = 4'd5; rl = 1'b0;
    smp();
    chk("rst_beat1", 64'(rv_v), 64'(4'b0100));
    cyc();
    ARESET = 1'b1; rv = 1'b0; arv = 4'b1011;
    cyc();
    ARESET = 1'b0; rv = 1'b1; rid = 4'd5;
    smp();
    chk("rst_values", 64'(snap()), 64'(0));
    cyc();
    rl = 1'b1;
    smp();
    chk("rst_next_grant", 64'({axi_arvalid, grant, rv_v, err_len, err_timeout}),
        64'({1'b1, 2'd0, 4'b0000, 1'b0, 1'b0}));
    cyc();
    rv = 1'b0; rl = 1'b0; ardy = 1'b1;
    smp();
    chk("rst_m0_arready", 64'(ardy_v), 64'(4'b0001));
    cyc();
    arv = 4'b0000; ardy = 1'b0; rv = 1'b1; rid = 4'd1; rl = 1'b1;
    rdata = {8{32'hA5C3_0F96}};
    smp();
    chk("rst_m0_beat", 64'({rv_v, rl_v}), 64'({4'b0001, 4'b0001}));
    chk("rdata_bcast", 64'({m_rdata[0] == {8{32'hA5C3_0F96}}, m_rdata[1] == {8{32'hA5C3_0F96}},
                            m_rdata[2] == {8{32'hA5C3_0F96}}, m_rdata[3] == {8{32'hA5C3_0F96}}}),
        64'(4'b1111));
    cyc();
    rv = 1'b0; rl = 1'b0;
    smp();
    chk("rst_no_err", 64'({err_len, err_timeout}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
